// File: rtl/regfile_scoreboard_if.sv
// Bus between decode/writeback and the register file: two read ports, two write
// ports, issue port and scoreboard status.
interface regfile_scoreboard_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] rd_addr1;
    logic [ADDR_W-1:0] rd_addr2;
    logic [DATA_W-1:0] rd_data1;
    logic [DATA_W-1:0] rd_data2;
    logic              rd_busy1;
    logic              rd_busy2;
    logic              wr0_en;
    logic [ADDR_W-1:0] wr0_addr;
    logic [DATA_W-1:0] wr0_data;
    logic              wr1_en;
    logic [ADDR_W-1:0] wr1_addr;
    logic [DATA_W-1:0] wr1_data;
    logic              iss_en;
    logic [ADDR_W-1:0] iss_addr;
    logic [ADDR_W:0]   busy_count;

    modport master (
        output rd_addr1, rd_addr2, wr0_en, wr0_addr, wr0_data,
               wr1_en, wr1_addr, wr1_data, iss_en, iss_addr,
        input  rd_data1, rd_data2, rd_busy1, rd_busy2, busy_count
    );

    modport slave (
        input  rd_addr1, rd_addr2, wr0_en, wr0_addr, wr0_data,
               wr1_en, wr1_addr, wr1_data, iss_en, iss_addr,
        output rd_data1, rd_data2, rd_busy1, rd_busy2, busy_count
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// Two-read/two-write register file with optional write-to-read bypass and a
// per-register busy scoreboard plus occupancy counter for stall decisions.
module regfile_scoreboard #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int BYPASS     = 1,
    parameter int PRESET_IDX = 16,
    parameter int PRESET_VAL = 20
) (
    input logic                clk,
    input logic                reset,
    regfile_scoreboard_if.slave bus
);
    localparam int DEPTH = 2**ADDR_W;
    localparam int CW    = ADDR_W + 1;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:0]  busy_nxt;
    logic [CW-1:0]     busy_count_q;
    logic [CW-1:0]     count_nxt;

    logic w0, w1, iss, inc, d0, d1;

    // Writes and issues seen during reset are discarded, so they are not forwarded either.
    always_comb begin
        w0  = bus.wr0_en && (bus.wr0_addr != '0) && !reset;
        w1  = bus.wr1_en && (bus.wr1_addr != '0) && !reset;
        iss = bus.iss_en && (bus.iss_addr != '0) && !reset;
    end

    always_comb begin
        busy_nxt = busy;
        if (w0) busy_nxt[bus.wr0_addr] = 1'b0;
        if (w1) busy_nxt[bus.wr1_addr] = 1'b0;
        if (iss) busy_nxt[bus.iss_addr] = 1'b1;

        inc = iss && !busy[bus.iss_addr];
        d0  = w0 && busy[bus.wr0_addr] && !(iss && bus.iss_addr == bus.wr0_addr);
        // A second write to the same busy register must not decrement twice.
        d1  = w1 && busy[bus.wr1_addr] && !(iss && bus.iss_addr == bus.wr1_addr)
                 && !(w0 && bus.wr0_addr == bus.wr1_addr);
        count_nxt = busy_count_q + CW'(inc) - CW'(d0) - CW'(d1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= (PRESET_IDX != 0 && i == PRESET_IDX) ? DATA_W'(PRESET_VAL) : '0;
            end
            busy         <= '0;
            busy_count_q <= '0;
        end else begin
            if (w0) regs[bus.wr0_addr] <= bus.wr0_data;
            if (w1) regs[bus.wr1_addr] <= bus.wr1_data;
            busy         <= busy_nxt;
            busy_count_q <= count_nxt;
        end
    end

    always_comb begin
        bus.rd_data1 = (bus.rd_addr1 == '0) ? '0 : regs[bus.rd_addr1];
        bus.rd_data2 = (bus.rd_addr2 == '0) ? '0 : regs[bus.rd_addr2];
        bus.rd_busy1 = busy[bus.rd_addr1];
        bus.rd_busy2 = busy[bus.rd_addr2];
        if (BYPASS != 0) begin
            if (w1 && bus.wr1_addr == bus.rd_addr1)      bus.rd_data1 = bus.wr1_data;
            else if (w0 && bus.wr0_addr == bus.rd_addr1) bus.rd_data1 = bus.wr0_data;
            if (w1 && bus.wr1_addr == bus.rd_addr2)      bus.rd_data2 = bus.wr1_data;
            else if (w0 && bus.wr0_addr == bus.rd_addr2) bus.rd_data2 = bus.wr0_data;
            // A same-cycle issue to the register keeps it busy.
            if (((w0 && bus.wr0_addr == bus.rd_addr1) || (w1 && bus.wr1_addr == bus.rd_addr1))
                && !(iss && bus.iss_addr == bus.rd_addr1))
                bus.rd_busy1 = 1'b0;
            if (((w0 && bus.wr0_addr == bus.rd_addr2) || (w1 && bus.wr1_addr == bus.rd_addr2))
                && !(iss && bus.iss_addr == bus.rd_addr2))
                bus.rd_busy2 = 1'b0;
        end
    end

    assign bus.busy_count = busy_count_q;
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: one bypassing DUT and one non-bypassing
// DUT share the same stimulus.
module tb_regfile_scoreboard;
    logic clk;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    regfile_scoreboard_if #(.DATA_W(32), .ADDR_W(5)) bus ();
    regfile_scoreboard_if #(.DATA_W(32), .ADDR_W(5)) bus_n ();

    regfile_scoreboard #(.BYPASS(1)) dut (.clk(clk), .reset(reset), .bus(bus));
    regfile_scoreboard #(.BYPASS(0)) dut_n (.clk(clk), .reset(reset), .bus(bus_n));

    assign bus_n.rd_addr1 = bus.rd_addr1;
    assign bus_n.rd_addr2 = bus.rd_addr2;
    assign bus_n.wr0_en   = bus.wr0_en;
    assign bus_n.wr0_addr = bus.wr0_addr;
    assign bus_n.wr0_data = bus.wr0_data;
    assign bus_n.wr1_en   = bus.wr1_en;
    assign bus_n.wr1_addr = bus.wr1_addr;
    assign bus_n.wr1_data = bus.wr1_data;
    assign bus_n.iss_en   = bus.iss_en;
    assign bus_n.iss_addr = bus.iss_addr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        bus.wr0_en = 1'b0;
        bus.wr1_en = 1'b0;
        bus.iss_en = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        bus.rd_addr1 = 5'd16; bus.rd_addr2 = 5'd5;
        bus.wr0_addr = '0; bus.wr0_data = '0;
        bus.wr1_addr = '0; bus.wr1_data = '0;
        bus.iss_addr = '0;
        idle();
        tick(); tick();
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_checks++;
        if (bus.rd_data1 !== 32'd20) begin
            n_fail++; $display("FAIL reset_preset: got %0d expected 20", bus.rd_data1);
        end
        n_checks++;
        if (bus.rd_data2 !== 32'd0) begin
            n_fail++; $display("FAIL reset_reg5: got %0d expected 0", bus.rd_data2);
        end
        n_checks++;
        if (bus.busy_count !== 6'd0) begin
            n_fail++; $display("FAIL reset_count: got %0d expected 0", bus.busy_count);
        end
        for (int a = 0; a < 32; a++) begin
            bus.rd_addr1 = 5'(a);
            #1;
            n_checks++;
            if (bus.rd_busy1 !== 1'b0) begin
                n_fail++; $display("FAIL reset_busy[%0d]: got %0b expected 0", a, bus.rd_busy1);
            end
        end
    endtask

    task automatic test_bypass;
        bus.wr0_en = 1'b1; bus.wr0_addr = 5'd3; bus.wr0_data = 32'hDEADBEEF;
        bus.rd_addr1 = 5'd3;
        #1;
        n_checks++;
        if (bus.rd_data1 !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL bypass_same_cycle: got %h expected deadbeef", bus.rd_data1);
        end
        n_checks++;
        if (bus_n.rd_data1 !== 32'h0) begin
            n_fail++; $display("FAIL nobypass_same_cycle: got %h expected 00000000", bus_n.rd_data1);
        end
        tick();
        idle();
        #1;
        n_checks++;
        if (bus_n.rd_data1 !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL nobypass_next_cycle: got %h expected deadbeef", bus_n.rd_data1);
        end
        n_checks++;
        if (bus.rd_data1 !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL bypass_stored: got %h expected deadbeef", bus.rd_data1);
        end
    endtask

    task automatic test_dual_write;
        bus.wr0_en = 1'b1; bus.wr0_addr = 5'd7; bus.wr0_data = 32'h11;
        bus.wr1_en = 1'b1; bus.wr1_addr = 5'd7; bus.wr1_data = 32'h22;
        bus.rd_addr1 = 5'd7;
        #1;
        n_checks++;
        if (bus.rd_data1 !== 32'h22) begin
            n_fail++; $display("FAIL dual_fwd: got %h expected 22", bus.rd_data1);
        end
        tick();
        idle();
        #1;
        n_checks++;
        if (bus.rd_data1 !== 32'h22) begin
            n_fail++; $display("FAIL dual_stored: got %h expected 22", bus.rd_data1);
        end
        n_checks++;
        if (bus_n.rd_data1 !== 32'h22) begin
            n_fail++; $display("FAIL dual_stored_nb: got %h expected 22", bus_n.rd_data1);
        end
        bus.wr0_en = 1'b1; bus.wr0_addr = 5'd0; bus.wr0_data = 32'hFFFF_FFFF;
        bus.rd_addr2 = 5'd0;
        #1;
        n_checks++;
        if (bus.rd_data2 !== 32'h0) begin
            n_fail++; $display("FAIL r0_fwd: got %h expected 0", bus.rd_data2);
        end
        tick();
        idle();
        #1;
        n_checks++;
        if (bus.rd_data2 !== 32'h0) begin
            n_fail++; $display("FAIL r0_stored: got %h expected 0", bus.rd_data2);
        end
    endtask

    task automatic test_issue;
        bus.rd_addr1 = 5'd4;
        bus.iss_en = 1'b1; bus.iss_addr = 5'd4;
        #1;
        n_checks++;
        if (bus.rd_busy1 !== 1'b0) begin
            n_fail++; $display("FAIL issue_no_fwd: got %0b expected 0", bus.rd_busy1);
        end
        for (int k = 0; k < 3; k++) begin
            bus.iss_addr = 5'(4 + k);
            tick();
            n_checks++;
            if (bus.busy_count !== 6'(k + 1)) begin
                n_fail++; $display("FAIL issue_count%0d: got %0d expected %0d", k, bus.busy_count, k + 1);
            end
        end
        idle();
        #1;
        n_checks++;
        if (bus.rd_busy1 !== 1'b1) begin
            n_fail++; $display("FAIL issue_busy4: got %0b expected 1", bus.rd_busy1);
        end
        bus.wr0_en = 1'b1; bus.wr0_addr = 5'd4; bus.wr0_data = 32'h44;
        bus.wr1_en = 1'b1; bus.wr1_addr = 5'd5; bus.wr1_data = 32'h55;
        bus.rd_addr2 = 5'd5;
        #1;
        n_checks++;
        if (bus.rd_busy1 !== 1'b0 || bus.rd_busy2 !== 1'b0) begin
            n_fail++; $display("FAIL busy_clear_fwd: got %0b%0b expected 00", bus.rd_busy1, bus.rd_busy2);
        end
        n_checks++;
        if (bus_n.rd_busy1 !== 1'b1 || bus_n.rd_busy2 !== 1'b1) begin
            n_fail++; $display("FAIL busy_clear_nb: got %0b%0b expected 11", bus_n.rd_busy1, bus_n.rd_busy2);
        end
        tick();
        idle();
        #1;
        n_checks++;
        if (bus.busy_count !== 6'd1) begin
            n_fail++; $display("FAIL retire_count: got %0d expected 1", bus.busy_count);
        end
        n_checks++;
        if (bus_n.rd_busy1 !== 1'b0 || bus_n.rd_busy2 !== 1'b0) begin
            n_fail++; $display("FAIL retire_busy45: got %0b%0b expected 00", bus_n.rd_busy1, bus_n.rd_busy2);
        end
        n_checks++;
        if (bus.rd_data1 !== 32'h44 || bus.rd_data2 !== 32'h55) begin
            n_fail++; $display("FAIL retire_data: got %h %h expected 44 55", bus.rd_data1, bus.rd_data2);
        end
        bus.rd_addr1 = 5'd6;
        #1;
        n_checks++;
        if (bus.rd_busy1 !== 1'b1) begin
            n_fail++; $display("FAIL busy6: got %0b expected 1", bus.rd_busy1);
        end
    endtask

    task automatic test_collision;
        bus.iss_en = 1'b1; bus.iss_addr = 5'd9;
        tick();
        n_checks++;
        if (bus.busy_count !== 6'd2) begin
            n_fail++; $display("FAIL iss9_count: got %0d expected 2", bus.busy_count);
        end
        bus.wr1_en = 1'b1; bus.wr1_addr = 5'd9; bus.wr1_data = 32'h99;
        bus.rd_addr1 = 5'd9;
        #1;
        n_checks++;
        if (bus.rd_busy1 !== 1'b1) begin
            n_fail++; $display("FAIL coll_busy_fwd: got %0b expected 1", bus.rd_busy1);
        end
        tick();
        idle();
        #1;
        n_checks++;
        if (bus.busy_count !== 6'd2 || bus.rd_busy1 !== 1'b1) begin
            n_fail++; $display("FAIL coll_after: got count %0d busy %0b expected 2 1", bus.busy_count, bus.rd_busy1);
        end
        n_checks++;
        if (bus.rd_data1 !== 32'h99) begin
            n_fail++; $display("FAIL coll_data: got %h expected 99", bus.rd_data1);
        end
        bus.iss_en = 1'b1; bus.iss_addr = 5'd0;
        tick();
        idle();
        bus.rd_addr2 = 5'd0;
        #1;
        n_checks++;
        if (bus.busy_count !== 6'd2 || bus.rd_busy2 !== 1'b0) begin
            n_fail++; $display("FAIL iss0: got count %0d busy %0b expected 2 0", bus.busy_count, bus.rd_busy2);
        end
        bus.wr0_en = 1'b1; bus.wr0_addr = 5'd9; bus.wr0_data = 32'hA0;
        bus.wr1_en = 1'b1; bus.wr1_addr = 5'd9; bus.wr1_data = 32'hA1;
        tick();
        idle();
        #1;
        n_checks++;
        if (bus.busy_count !== 6'd1 || bus.rd_busy1 !== 1'b0) begin
            n_fail++; $display("FAIL dual_retire: got count %0d busy %0b expected 1 0", bus.busy_count, bus.rd_busy1);
        end
        n_checks++;
        if (bus.rd_data1 !== 32'hA1) begin
            n_fail++; $display("FAIL dual_retire_data: got %h expected a1", bus.rd_data1);
        end
        bus.wr0_en = 1'b1; bus.wr0_addr = 5'd12; bus.wr0_data = 32'hC;
        tick();
        idle();
        bus.rd_addr2 = 5'd12;
        #1;
        n_checks++;
        if (bus.busy_count !== 6'd1 || bus.rd_data2 !== 32'hC) begin
            n_fail++; $display("FAIL nonbusy_write: got count %0d data %h expected 1 c", bus.busy_count, bus.rd_data2);
        end
    endtask

    task automatic test_async_reset;
        bus.iss_en = 1'b1; bus.iss_addr = 5'd10;
        tick();
        idle();
        n_checks++;
        if (bus.busy_count !== 6'd2) begin
            n_fail++; $display("FAIL iss10_count: got %0d expected 2", bus.busy_count);
        end
        bus.wr0_en = 1'b1; bus.wr0_addr = 5'd10; bus.wr0_data = 32'h1234;
        bus.rd_addr1 = 5'd10; bus.rd_addr2 = 5'd16;
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if (bus.busy_count !== 6'd0 || bus.rd_busy1 !== 1'b0) begin
            n_fail++; $display("FAIL async_clear: got count %0d busy %0b expected 0 0", bus.busy_count, bus.rd_busy1);
        end
        n_checks++;
        if (bus_n.rd_data1 !== 32'h0 || bus.rd_data2 !== 32'd20) begin
            n_fail++; $display("FAIL async_regs: got %h %0d expected 0 20", bus_n.rd_data1, bus.rd_data2);
        end
        tick();
        @(negedge clk);
        idle();
        reset = 1'b0;
        #1;
        n_checks++;
        if (bus.rd_data1 !== 32'h0 || bus.busy_count !== 6'd0) begin
            n_fail++; $display("FAIL after_reset: got %h count %0d expected 0 0", bus.rd_data1, bus.busy_count);
        end
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_dual_write();
        test_issue();
        test_collision();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

Parametrised register file for the single-cycle/multi-cycle MIPS datapath, successor to the 32x32 two-read/one-write bank. Adds a second write port for late-result units (load, multiply), optional write-to-read bypass, a configurable reset preset register, and a per-register busy scoreboard with an occupancy counter so the control unit can stall on pending results. Sits between decode (read/issue) and writeback (write ports).

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W
- BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads show stored value only
- PRESET_IDX, 16, register loaded with PRESET_VAL on reset (0 disables preset)
- PRESET_VAL, 20, reset value of register PRESET_IDX
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- rd_addr1, rd_addr2  in  ADDR_W  read addresses
- rd_data1, rd_data2  out  DATA_W  combinational read data
- rd_busy1, rd_busy2  out  1  combinational busy flag of addressed register
- wr0_en  in  1  write port 0 enable (ALU writeback)
- wr0_addr  in  ADDR_W  port 0 address
- wr0_data  in  DATA_W  port 0 data
- wr1_en, wr1_addr, wr1_data  in  1/ADDR_W/DATA_W  write port 1 (load/multiply writeback)
- iss_en  in  1  issue: mark iss_addr as pending
- iss_addr  in  ADDR_W  destination register being issued
- busy_count  out  ADDR_W+1  registered number of busy registers

## Operation
- Reset (async, any time): all registers 0 except PRESET_IDX = PRESET_VAL; all busy bits 0; busy_count 0. Clears in-flight state; writes/issues in the reset cycle are discarded.
- Register 0: always reads 0, writes ignored, never busy, issue to 0 ignored.
- Writes: at rising edge, wrN_en with nonzero address stores wrN_data. Both ports same address same cycle: port 1 wins (stored and forwarded).
- Reads: rd_dataK = stored value of rd_addrK. If BYPASS=1 and a write to rd_addrK is enabled this cycle, rd_dataK = that write data (port 1 over port 0).
- Scoreboard: iss_en sets busy[iss_addr]; any enabled write clears busy[addr] of that write. Issue and write to the same address in one cycle: busy stays/sets to 1 (new producer wins). Issue to an already-busy register: stays 1, no count change.
- rd_busyK = busy[rd_addrK]; with BYPASS=1, reports 0 if a write to that address clears it this cycle and no same-address issue.
- busy_count: next = current + (issue sets a clear bit) - (number of distinct set bits cleared by writes). Both ports writing the same busy register decrement once. Range 0..2**ADDR_W-1, never wraps; must always equal popcount(busy).
- Write to a non-busy register: data stored, busy unchanged, no decrement.

## Timing
- Write latency: 1 cycle to storage; 0 cycles to reads when BYPASS=1.
- Issue latency: busy visible on rd_busy next cycle (no same-cycle issue forwarding).
- busy_count reflects state after the previous edge; updated every edge.
- Reads and rd_busy purely combinational from addresses, state and same-cycle write ports.
- Reset deassertion: first normal update on the next rising edge.

## Test plan
- Reset, then read addr 16 and addr 5 -> rd_data 20 and 0; busy_count 0; all rd_busy 0.
- wr0 addr 3 = 0xDEADBEEF, read addr 3 same cycle -> BYPASS=1: 0xDEADBEEF; BYPASS=0: old value, 0xDEADBEEF next cycle.
- wr0 and wr1 both addr 7 (0x11, 0x22) -> rd_data 0x22 same cycle (bypass) and after edge; write to addr 0 -> reads 0.
- Issue 4, 5, 6 on consecutive cycles -> busy_count 1,2,3; then wr0=4 and wr1=5 same cycle -> busy_count 1, rd_busy(4)=rd_busy(5)=0, rd_busy(6)=1.
- Issue 9 and wr1 to 9 same cycle while 9 busy -> busy stays 1, count unchanged; issue 0 -> ignored, count unchanged.
- Issue 10 then assert reset mid-sequence with wr0 pending -> busy_count 0, rd_busy 0, reg 10 = 0, reg 16 = 20 immediately (async).
